butterfly_sequencer: RTL and testbench

- Initiator that drives the butterfly array for a multi-stage NTT pass.
- Per stage, issues one row of SIZE butterflies per cycle: coefficient-memory read address, twiddle ROM index, mode and swap.
- Delays each issued row address through a LATENCY-deep tag pipeline so the write-back address and enable line up with the array outputs.
- Drains the pipeline between stages to prevent read-after-write hazards on the in-place coefficient memory.

---
 rtl/bfly_seq_pkg.sv | 20 ++
 rtl/bfly_tag_delay.sv | 34 +++
 rtl/butterfly_sequencer.sv | 153 +++++++++++++++
 tb/tb_butterfly_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bfly_seq_pkg.sv
// Shared types and width helpers for the butterfly sequencer.
package bfly_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Row-address width; a single-row memory still gets a 1-bit address.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int widx_width(input int lut_size);
    return (lut_size > 1) ? $clog2(lut_size) : 1;
  endfunction

endpackage

// File: rtl/bfly_tag_delay.sv
// LATENCY-deep {valid, addr} shift register; reset (active low, synchronous) clears all valid bits.
module bfly_tag_delay #(
  parameter int AW      = 6,
  parameter int LATENCY = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_valid,
  input  logic [AW-1:0] push_addr,
  output logic          tag_valid,
  output logic [AW-1:0] tag_addr
);

  logic [LATENCY-1:0] valid_sr;
  logic [AW-1:0]      addr_sr [LATENCY];

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_sr <= '0;
      for (int i = 0; i < LATENCY; i++) addr_sr[i] <= '0;
    end else begin
      valid_sr[0] <= push_valid;
      addr_sr[0]  <= push_addr;
      for (int i = 1; i < LATENCY; i++) begin
        valid_sr[i] <= valid_sr[i-1];
        addr_sr[i]  <= addr_sr[i-1];
      end
    end
  end

  assign tag_valid = valid_sr[LATENCY-1];
  assign tag_addr  = addr_sr[LATENCY-1];

endmodule

// File: rtl/butterfly_sequencer.sv
// Issues NTT butterfly rows stage by stage, draining the write-back tag pipeline between stages.
// Define BFLY_PERF_CNT_EN to build the saturating busy-cycle counter on perf_cycles.
module butterfly_sequencer
  import bfly_seq_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 128,
  parameter int LUT_SIZE = 1360,
  parameter int DEPTH    = 64,
  parameter int LATENCY  = 4,
  localparam int AW      = addr_width(DEPTH),
  localparam int WW      = widx_width(LUT_SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [3:0]    cfg_stages,
  input  logic [AW:0]   cfg_rows,
  input  logic [WW-1:0] cfg_w_base,
  input  logic          cfg_mode,
  input  logic          cfg_swap,
  input  logic          hold,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic [WW-1:0] w_idx,
  output logic          mode,
  output logic          swap,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          busy,
  output logic          done,
  output logic [31:0]   perf_cycles
);

  localparam int            DW         = addr_width(LATENCY);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(LATENCY - 1);
  localparam logic [WW-1:0] W_LAST     = WW'(LUT_SIZE - 1);

  if (LATENCY < 1 || WIDTH < 1 || SIZE < 1) begin : g_param_check
    $error("butterfly_sequencer: LATENCY, WIDTH and SIZE must all be at least 1");
  end

  state_t        state, state_next;
  logic [AW-1:0] row;
  logic [3:0]    stage, stages_q;
  logic [AW:0]   rows_q;
  logic [DW-1:0] drain_cnt;
  logic          start_accept, row_last, stage_last, drain_end;

  assign row_last   = ({1'b0, row} == rows_q - (AW+1)'(1));
  assign stage_last = (stage == stages_q - 4'd1);
  assign drain_end  = (drain_cnt == DRAIN_LAST);
  assign rd_addr    = row;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // A start arriving while busy is still high (the done cycle) is not accepted.
  always_comb begin
    state_next   = state;
    rd_en        = 1'b0;
    start_accept = 1'b0;
    case (state)
      IDLE: begin
        if (start && !busy) begin
          start_accept = 1'b1;
          state_next   = (cfg_stages == 4'd0 || cfg_rows == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        rd_en = !hold;
        if (!hold && row_last) state_next = DRAIN;
      end
      DRAIN: begin
        if (drain_end) state_next = stage_last ? DONE : ISSUE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      row       <= '0;
      stage     <= '0;
      stages_q  <= '0;
      rows_q    <= '0;
      w_idx     <= '0;
      drain_cnt <= '0;
      mode      <= 1'b0;
      swap      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (start_accept) begin
        busy      <= 1'b1;
        stages_q  <= cfg_stages;
        rows_q    <= cfg_rows;
        mode      <= cfg_mode;
        swap      <= cfg_swap;
        row       <= '0;
        stage     <= '0;
        w_idx     <= cfg_w_base;
        drain_cnt <= '0;
      end else if (done) begin
        busy <= 1'b0;
      end
      if (state == DONE) begin
        mode <= 1'b0;
        swap <= 1'b0;
      end
      if (rd_en) begin
        row   <= row_last ? '0 : row + AW'(1);
        w_idx <= (w_idx == W_LAST) ? '0 : w_idx + WW'(1);
      end
      // twiddle index deliberately carries on across stages
      if (state == DRAIN) begin
        drain_cnt <= drain_end ? '0 : drain_cnt + DW'(1);
        if (drain_end && !stage_last) stage <= stage + 4'd1;
      end
    end
  end

  bfly_tag_delay #(
    .AW      (AW),
    .LATENCY (LATENCY)
  ) u_tag_delay (
    .clk        (clk),
    .reset      (reset),
    .push_valid (rd_en),
    .push_addr  (rd_addr),
    .tag_valid  (wr_en),
    .tag_addr   (wr_addr)
  );

`ifdef BFLY_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (!reset)                         perf_q <= '0;
    else if (start_accept)              perf_q <= '0;
    else if (busy && perf_q != '1)      perf_q <= perf_q + 32'd1;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_butterfly_sequencer.sv
// Scoreboard bench for butterfly_sequencer: read and write-back rows are predicted per pass and matched cycle by cycle.
module tb_butterfly_sequencer;

  localparam int WIDTH    = 32;
  localparam int SIZE     = 128;
  localparam int LUT_SIZE = 1360;
  localparam int DEPTH    = 64;
  localparam int LATENCY  = 4;
  localparam int AW       = 6;
  localparam int WW       = 11;
  localparam int RW       = 32 + AW + WW;
  localparam int TW       = 32 + AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    cfg_stages = '0;
  logic [AW:0]   cfg_rows = '0;
  logic [WW-1:0] cfg_w_base = '0;
  logic          cfg_mode = 1'b0;
  logic          cfg_swap = 1'b0;
  logic          hold = 1'b0;
  logic          rd_en, mode, swap, wr_en, busy, done;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [WW-1:0] w_idx;
  logic [31:0]   perf_cycles;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [RW-1:0] rd_exp_q[$];
  logic [TW-1:0] wr_exp_q[$];
  logic [RW-1:0] rd_e;
  logic [TW-1:0] wr_e;
  logic          mode_exp = 1'b0;
  logic          swap_exp = 1'b0;
  bit            done_seen = 1'b0;
  int            done_cyc = 0;
  int            done_cnt = 0;

  butterfly_sequencer #(
    .WIDTH    (WIDTH),
    .SIZE     (SIZE),
    .LUT_SIZE (LUT_SIZE),
    .DEPTH    (DEPTH),
    .LATENCY  (LATENCY)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cfg_stages  (cfg_stages),
    .cfg_rows    (cfg_rows),
    .cfg_w_base  (cfg_w_base),
    .cfg_mode    (cfg_mode),
    .cfg_swap    (cfg_swap),
    .hold        (hold),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .w_idx       (w_idx),
    .mode        (mode),
    .swap        (swap),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .busy        (busy),
    .done        (done),
    .perf_cycles (perf_cycles)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // monitor: compare issued rows and write-backs against the expected queues
  always @(negedge clk) begin
    if (reset) begin
      if (rd_en) begin
        check("rd_vs_hold", 64'(hold), 64'(0));
        if (rd_exp_q.size() == 0) begin
          check("rd_unexpected", 64'(rd_en), 64'(0));
        end else begin
          rd_e = rd_exp_q.pop_front();
          check("rd", {32'(cyc), rd_addr, w_idx}, rd_e);
          check("mode", 64'(mode), 64'(mode_exp));
          check("swap", 64'(swap), 64'(swap_exp));
          wr_exp_q.push_back({32'(cyc + LATENCY), rd_e[AW+WW-1:WW]});
        end
      end
      if (wr_exp_q.size() > 0) begin
        wr_e = wr_exp_q[0];
        if (wr_e[TW-1:AW] == 32'(cyc)) begin
          void'(wr_exp_q.pop_front());
          check("wr_en", 64'(wr_en), 64'(1));
          check("wr_addr", 64'(wr_addr), 64'(wr_e[AW-1:0]));
        end else if (wr_en) begin
          check("wr_unexpected", 64'(wr_en), 64'(0));
        end
      end else if (wr_en) begin
        check("wr_unexpected", 64'(wr_en), 64'(0));
      end
      if (done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
        done_cnt++;
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    hold  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_rd_en", 64'(rd_en), 64'(0));
    check("rst_wr_en", 64'(wr_en), 64'(0));
    check("rst_mode_swap", {mode, swap}, 64'(0));
    check("rst_w_idx", 64'(w_idx), 64'(0));
    check("rst_rd_addr", 64'(rd_addr), 64'(0));
    check("rst_perf", 64'(perf_cycles), 64'(0));
    reset = 1'b1;
    rd_exp_q.delete();
    wr_exp_q.delete();
  endtask

  // driver: one pass; hold is raised for hold_len cycles starting hold_at cycles into stage 0,
  // and a spurious start is pulsed poke_at cycles after accept (negative = none)
  task automatic run_pass(input int stages, input int rows, input int wbase, input bit m, input bit s,
                          input int hold_at, input int hold_len, input int poke_at);
    int acc, total, w, off;
    @(posedge clk); #1;
    cfg_stages = 4'(stages);
    cfg_rows   = (AW+1)'(rows);
    cfg_w_base = WW'(wbase);
    cfg_mode   = m;
    cfg_swap   = s;
    start      = 1'b1;
    done_seen  = 1'b0;
    done_cnt   = 0;
    @(posedge clk); #1;
    start      = 1'b0;
    acc        = cyc;
    cfg_stages = 4'($urandom_range(0, 15));
    cfg_rows   = (AW+1)'($urandom_range(0, DEPTH));
    cfg_w_base = WW'($urandom_range(0, LUT_SIZE - 1));
    cfg_mode   = ~m;
    cfg_swap   = ~s;
    mode_exp   = m;
    swap_exp   = s;
    total = (stages == 0 || rows == 0) ? 2 : stages * (rows + LATENCY) + 2 + hold_len;
    w = wbase;
    for (int si = 0; si < stages; si++) begin
      for (int ri = 0; ri < rows; ri++) begin
        off = si * (rows + LATENCY) + ri + ((hold_len > 0 && (si > 0 || ri >= hold_at)) ? hold_len : 0);
        rd_exp_q.push_back({32'(acc + off), AW'(ri), WW'(w)});
        w = (w == LUT_SIZE - 1) ? 0 : w + 1;
      end
    end
    check("busy_after_start", 64'(busy), 64'(1));
    for (int k = 0; k < total + 20 && !done_seen; k++) begin
      hold = (hold_len > 0 && k >= hold_at && k < hold_at + hold_len);
      if (k == poke_at) begin
        start      = 1'b1;
        cfg_stages = 4'd2;
        cfg_rows   = (AW+1)'(3);
        cfg_w_base = '0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    hold  = 1'b0;
    check("done_seen", 64'(done_seen), 64'(1));
    check("done_cycle", 64'(done_cyc), 64'(acc + total - 1));
    check("busy_clear", 64'(busy), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    check("done_pulses", 64'(done_cnt), 64'(1));
    check("rd_queue_empty", 64'(rd_exp_q.size()), 64'(0));
    check("wr_queue_empty", 64'(wr_exp_q.size()), 64'(0));
    check("mode_swap_idle", {mode, swap}, 64'(0));
`ifdef BFLY_PERF_CNT_EN
    check("perf_cycles", 64'(perf_cycles), 64'(total));
`else
    check("perf_cycles", 64'(perf_cycles), 64'(0));
`endif
  endtask

  // reset asserted with three rows in flight; none of them may be written back
  task automatic reset_mid();
    int acc;
    @(posedge clk); #1;
    cfg_stages = 4'd1;
    cfg_rows   = (AW+1)'(8);
    cfg_w_base = WW'(100);
    cfg_mode   = 1'b0;
    cfg_swap   = 1'b0;
    start      = 1'b1;
    done_seen  = 1'b0;
    done_cnt   = 0;
    @(posedge clk); #1;
    start    = 1'b0;
    acc      = cyc;
    mode_exp = 1'b0;
    swap_exp = 1'b0;
    for (int ri = 0; ri < 3; ri++) rd_exp_q.push_back({32'(acc + ri), AW'(ri), WW'(100 + ri)});
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    rd_exp_q.delete();
    wr_exp_q.delete();
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_rd_en", 64'(rd_en), 64'(0));
    repeat (LATENCY + 4) @(posedge clk);
    #1;
    check("mid_rst_no_done", 64'(done_seen), 64'(0));
    check("mid_rst_busy_idle", 64'(busy), 64'(0));
  endtask

  initial begin
    int st, rw, ha, hl;
    apply_reset();
    run_pass(1, 4, 10, 1'b0, 1'b0, 0, 0, -1);
    run_pass(3, 2, 20, 1'b1, 1'b0, 0, 0, 3);
    run_pass(1, 4, 50, 1'b0, 1'b1, 1, 2, -1);
    run_pass(1, 4, 1358, 1'b1, 1'b1, 0, 0, -1);
    run_pass(2, 3, 1357, 1'b0, 1'b0, 0, 0, -1);
    run_pass(0, 5, 0, 1'b1, 1'b0, 0, 0, 0);
    run_pass(2, 0, 0, 1'b0, 1'b1, 0, 0, -1);
    reset_mid();
    run_pass(1, 3, 7, 1'b1, 1'b0, 0, 0, -1);
    run_pass(1, DEPTH, 1300, 1'b0, 1'b1, 0, 0, DEPTH + 2);
    for (int i = 0; i < 5; i++) begin
      st = $urandom_range(1, 3);
      rw = $urandom_range(1, 8);
      ha = $urandom_range(0, rw - 1);
      hl = $urandom_range(0, 3);
      run_pass(st, rw, $urandom_range(0, LUT_SIZE - 1), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), ha, hl, -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
